sum_bcd_seg_display: RTL and testbench
======================================

Name: sum_bcd_seg_display

Overview:
- Downstream display stage for the 4-bit adder. Takes the binary sum, including carry, as an unsigned value up to 2^WIDTH-1.
- Converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine, then registers 9-bit seven-segment patterns for the left (tens) and right (units) digits.
- Load/busy/valid handshake, so the producer can strobe a new sum at any time.

Parameters:
- WIDTH, 5, bit width of bin; legal range 4..7 (default covers 15+15=30).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- load  input  1  single-cycle strobe; bin sampled on the clk edge where load=1 and FSM is IDLE.
- bin  input  WIDTH  unsigned binary value to display.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse when seg_left/seg_right update with a new result.
- ovf  output  1  registered; 1 when last converted value > 99.
- seg_left  output  9  tens-digit pattern.
- seg_right  output  9  units-digit pattern.

Behaviour:
- Segment encoding: bit0..6 = a..g, active high; bit7 (dp) = 0; bit8 = 0.
- Digit codes: 0=9'h03f, 1=9'h006, 2=9'h05b, 3=9'h04f, 4=9'h066, 5=9'h06d, 6=9'h07d, 7=9'h007, 8=9'h07f, 9=9'h06f.
- Dash = 9'h040; blank = 9'h000.
- Reset (asynchronous, rst=0):
  - FSM to IDLE; busy=0, valid=0, ovf=0.
  - seg_left=9'h03f, seg_right=9'h03f; internal shift register and counter cleared.
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - load=1 → capture bin into shift register, clear BCD nibbles, counter=0, go to SHIFT, busy=1 from next cycle.
  - load=0 → stay.
- SHIFT:
  - Each cycle, add 3 to any BCD nibble (tens, units, hundreds) >= 5, then shift {hundreds,tens,units,bin_shift} left by 1.
  - After exactly WIDTH shift cycles, go to UPDATE.
- UPDATE:
  - Register decoded patterns into seg_left/seg_right, set ovf, pulse valid=1 for this one cycle.
  - busy=0 from the next cycle; return to IDLE.
- Latency: load edge at cycle 0 → valid=1 and new segments visible in cycle WIDTH+1 (cycle 6 for WIDTH=5). Next load is accepted in cycle WIDTH+2.
- Overflow: hundreds nibble != 0 → seg_left=seg_right=9'h040, ovf=1. Only reachable when WIDTH=7 (100..127).
- load while busy: ignored entirely; the in-flight conversion finishes with the originally captured value. No queueing.
- load in the UPDATE cycle is also ignored (busy still 1).
- bin changing after capture has no effect.
- seg_left/seg_right hold their last value between updates; valid is never asserted outside UPDATE.
- rst asserted mid-conversion: conversion aborts immediately; outputs return to reset values; no valid pulse.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in UPDATE, when tens=0 and no overflow, seg_left=9'h000 (blank). Reset value of seg_left is unchanged (9'h03f).
- Undefined: tens=0 displays 9'h03f.
- Right digit is never blanked in either case.

Test Plan:
- Reset: hold rst=0 3 cycles, release → seg_left=seg_right=9'h03f, busy=0, valid=0, ovf=0; no change without load.
- WIDTH=5, load with bin=27 at cycle 0 → busy=1 cycles 1..6; valid=1 only at cycle 6; seg_left=9'h05b, seg_right=9'h007, ovf=0.
- WIDTH=5, bin=9 → seg_left=9'h03f (9'h000 with LEADING_ZERO_BLANK_EN), seg_right=9'h06f. Then bin=30 → 9'h04f / 9'h03f.
- WIDTH=5, load bin=12, then load bin=25 at cycle 3 while busy → single valid pulse; result 9'h006 / 9'h05b; the second load is lost.
- load bin=19, drive rst=0 at cycle 3 → immediate reset values, no valid pulse. After release, load bin=5 → 9'h03f / 9'h06d at cycle WIDTH+1.
- WIDTH=7: bin=120 → seg_left=seg_right=9'h040, ovf=1, valid at cycle 8. Then bin=99 → 9'h06f / 9'h06f, ovf=0.

Source files
------------

// File: rtl/sum_bcd_seg_display.sv
// Sum display stage: a serial double-dabble converter followed by registered seven-segment digits.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module sum_bcd_seg_display #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] bin,
    output logic             busy,
    output logic             valid,
    output logic             ovf,
    output logic [8:0]       seg_left,
    output logic [8:0]       seg_right
);

    localparam int          SR_W      = 12 + WIDTH;
    localparam logic [8:0]  SEG_ZERO  = 9'h03f;
    localparam logic [8:0]  SEG_DASH  = 9'h040;
    localparam logic [2:0]  LAST_SHIFT = 3'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [SR_W-1:0] r_sr;
    logic [SR_W-1:0] w_adj;
    logic [SR_W-1:0] w_shifted;
    logic [2:0]      r_cnt;
    logic            w_last_shift;
    logic [3:0]      w_hund;
    logic [3:0]      w_tens;
    logic [3:0]      w_units;
    logic            w_ovf;
    logic [8:0]      w_seg_left;
    logic [8:0]      w_seg_right;
    logic            r_ovf;
    logic [8:0]      r_seg_left;
    logic [8:0]      r_seg_right;

    function automatic logic [8:0] seg_decode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_decode = 9'h03f;
            4'd1:    seg_decode = 9'h006;
            4'd2:    seg_decode = 9'h05b;
            4'd3:    seg_decode = 9'h04f;
            4'd4:    seg_decode = 9'h066;
            4'd5:    seg_decode = 9'h06d;
            4'd6:    seg_decode = 9'h07d;
            4'd7:    seg_decode = 9'h007;
            4'd8:    seg_decode = 9'h07f;
            4'd9:    seg_decode = 9'h06f;
            default: seg_decode = 9'h000;
        endcase
    endfunction

    // Shift register layout: {hundreds, tens, units, remaining binary bits}.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_adj = r_sr;
        for (int i = 0; i < 3; i++) begin
            if (r_sr[WIDTH+4*i +: 4] >= 4'd5) begin
                w_adj[WIDTH+4*i +: 4] = r_sr[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        w_shifted = w_adj << 1;
    end

    assign w_last_shift = (r_cnt == LAST_SHIFT);
    assign w_hund       = w_shifted[WIDTH+8 +: 4];
    assign w_tens       = w_shifted[WIDTH+4 +: 4];
    assign w_units      = w_shifted[WIDTH +: 4];
    assign w_ovf        = (w_hund != 4'd0);

    always_comb begin
        w_seg_right = seg_decode(w_units);
        w_seg_left  = seg_decode(w_tens);
`ifdef LEADING_ZERO_BLANK_EN
        if (w_tens == 4'd0) begin
            w_seg_left = 9'h000;
        end
`endif
        if (w_ovf) begin
            w_seg_left  = SEG_DASH;
            w_seg_right = SEG_DASH;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load) w_next_state = SHIFT;
            SHIFT:   if (w_last_shift) w_next_state = UPDATE;
            UPDATE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Digits are written on the final shift edge so they are visible during the UPDATE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_seg_left  <= SEG_ZERO;
            r_seg_right <= SEG_ZERO;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_sr  <= {12'd0, bin};
                        r_cnt <= '0;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_shifted;
                    r_cnt <= r_cnt + 3'd1;
                    if (w_last_shift) begin
                        r_ovf       <= w_ovf;
                        r_seg_left  <= w_seg_left;
                        r_seg_right <= w_seg_right;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign valid     = (r_state == UPDATE);
    assign ovf       = r_ovf;
    assign seg_left  = r_seg_left;
    assign seg_right = r_seg_right;

endmodule

// File: tb/tb_sum_bcd_seg_display.sv
// Bench for sum_bcd_seg_display: WIDTH=5 and WIDTH=7 instances, each checked by a
// scoreboard queue filled at load time and drained when the instance pulses valid.
module tb_sum_bcd_seg_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load5 = 1'b0;
    logic       load7 = 1'b0;
    logic [4:0] bin5 = '0;
    logic [6:0] bin7 = '0;
    logic       busy5, valid5, ovf5, busy7, valid7, ovf7;
    logic [8:0] seg_left5, seg_right5, seg_left7, seg_right7;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int free5  = 0;
    int free7  = 0;

    typedef struct {
        logic [8:0] l;
        logic [8:0] r;
        logic       o;
        int         vcyc;
    } exp_t;

    exp_t q5[$];
    exp_t q7[$];

    logic [8:0] seg_tab [10] = '{9'h03f, 9'h006, 9'h05b, 9'h04f, 9'h066,
                                 9'h06d, 9'h07d, 9'h007, 9'h07f, 9'h06f};

    sum_bcd_seg_display #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .load(load5), .bin(bin5),
        .busy(busy5), .valid(valid5), .ovf(ovf5),
        .seg_left(seg_left5), .seg_right(seg_right5)
    );

    sum_bcd_seg_display #(.WIDTH(7)) dut7 (
        .clk(clk), .rst(rst), .load(load7), .bin(bin7),
        .busy(busy7), .valid(valid7), .ovf(ovf7),
        .seg_left(seg_left7), .seg_right(seg_right7)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: decimal digits by division; result expected in cycle c+WIDTH+1.
    function automatic exp_t model(input int v, input int w, input int c);
        exp_t e;
        int   t;
        int   u;
        t      = (v / 10) % 10;
        u      = v % 10;
        e.o    = (v > 99);
        e.vcyc = c + w + 1;
        if (e.o) begin
            e.l = 9'h040;
            e.r = 9'h040;
        end else begin
            e.r = seg_tab[u];
            e.l = seg_tab[t];
`ifdef LEADING_ZERO_BLANK_EN
            if (t == 0) e.l = 9'h000;
`endif
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (valid5) begin
            checks++;
            if (q5.size() == 0) begin
                errors++;
                $display("FAIL dut5_unexpected_valid cycle %0d: got valid=1, required 0", cyc);
            end else begin
                e = q5.pop_front();
                if (cyc !== e.vcyc) begin
                    errors++;
                    $display("FAIL dut5_valid_cycle: got %0d, required %0d", cyc, e.vcyc);
                end
                checks++;
                if (seg_left5 !== e.l) begin
                    errors++;
                    $display("FAIL dut5_seg_left: got %h, required %h", seg_left5, e.l);
                end
                checks++;
                if (seg_right5 !== e.r) begin
                    errors++;
                    $display("FAIL dut5_seg_right: got %h, required %h", seg_right5, e.r);
                end
                checks++;
                if (ovf5 !== e.o) begin
                    errors++;
                    $display("FAIL dut5_ovf: got %b, required %b", ovf5, e.o);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid7) begin
            checks++;
            if (q7.size() == 0) begin
                errors++;
                $display("FAIL dut7_unexpected_valid cycle %0d: got valid=1, required 0", cyc);
            end else begin
                e = q7.pop_front();
                if (cyc !== e.vcyc) begin
                    errors++;
                    $display("FAIL dut7_valid_cycle: got %0d, required %0d", cyc, e.vcyc);
                end
                checks++;
                if (seg_left7 !== e.l) begin
                    errors++;
                    $display("FAIL dut7_seg_left: got %h, required %h", seg_left7, e.l);
                end
                checks++;
                if (seg_right7 !== e.r) begin
                    errors++;
                    $display("FAIL dut7_seg_right: got %h, required %h", seg_right7, e.r);
                end
                checks++;
                if (ovf7 !== e.o) begin
                    errors++;
                    $display("FAIL dut7_ovf: got %b, required %b", ovf7, e.o);
                end
            end
        end
    end

    // Called just after a negedge; returns at the following negedge.
    task automatic load5_at(input int v);
        load5 = 1'b1;
        bin5  = 5'(v);
        if (cyc >= free5) begin
            q5.push_back(model(v, 5, cyc));
            free5 = cyc + 7;
        end
        @(negedge clk);
        load5 = 1'b0;
        bin5  = 5'($urandom);
    endtask

    task automatic load7_at(input int v);
        load7 = 1'b1;
        bin7  = 7'(v);
        if (cyc >= free7) begin
            q7.push_back(model(v, 7, cyc));
            free7 = cyc + 9;
        end
        @(negedge clk);
        load7 = 1'b0;
        bin7  = 7'($urandom);
    endtask

    task automatic drain5();
        int k = 0;
        while (q5.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (q5.size() != 0) begin
            errors++;
            $display("FAIL dut5_timeout: got %0d pending results, required 0", q5.size());
            q5.delete();
        end
        @(negedge clk);
        checks++;
        if (busy5 !== 1'b0) begin
            errors++;
            $display("FAIL dut5_busy_after_done: got %b, required 0", busy5);
        end
    endtask

    task automatic drain7();
        int k = 0;
        while (q7.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (q7.size() != 0) begin
            errors++;
            $display("FAIL dut7_timeout: got %0d pending results, required 0", q7.size());
            q7.delete();
        end
        @(negedge clk);
        checks++;
        if (busy7 !== 1'b0) begin
            errors++;
            $display("FAIL dut7_busy_after_done: got %b, required 0", busy7);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({busy5, valid5, ovf5, seg_left5, seg_right5} !== {3'b000, 9'h03f, 9'h03f}) begin
                errors++;
                $display("FAIL reset_state5: got %b %h %h, required 000 03f 03f",
                         {busy5, valid5, ovf5}, seg_left5, seg_right5);
            end
            checks++;
            if ({busy7, valid7, ovf7, seg_left7, seg_right7} !== {3'b000, 9'h03f, 9'h03f}) begin
                errors++;
                $display("FAIL reset_state7: got %b %h %h, required 000 03f 03f",
                         {busy7, valid7, ovf7}, seg_left7, seg_right7);
            end
        end
    endtask

    task automatic test_basic();
        load5_at(27);
        for (int k = 1; k <= 7; k++) begin
            checks++;
            if (busy5 !== 1'(k <= 6)) begin
                errors++;
                $display("FAIL busy_cycle%0d: got %b, required %b", k, busy5, 1'(k <= 6));
            end
            checks++;
            if (valid5 !== 1'(k == 6)) begin
                errors++;
                $display("FAIL valid_cycle%0d: got %b, required %b", k, valid5, 1'(k == 6));
            end
            @(negedge clk);
        end
        drain5();
    endtask

    task automatic test_digits();
        exp_t e;
        load5_at(9);
        drain5();
        load5_at(30);
        drain5();
        e = model(30, 5, 0);
        repeat (4) @(negedge clk);
        checks++;
        if ({seg_left5, seg_right5} !== {e.l, e.r}) begin
            errors++;
            $display("FAIL hold_segments: got %h %h, required %h %h", seg_left5, seg_right5, e.l, e.r);
        end
    endtask

    task automatic test_load_while_busy();
        load5_at(12);
        repeat (2) @(negedge clk);
        load5_at(25);
        drain5();
        repeat (10) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        load5_at(17);
        repeat (5) @(negedge clk);
        load5_at(3);
        load5_at(8);
        drain5();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_abort();
        load5_at(19);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({busy5, valid5, ovf5, seg_left5, seg_right5} !== {3'b000, 9'h03f, 9'h03f}) begin
            errors++;
            $display("FAIL abort_state: got %b %h %h, required 000 03f 03f",
                     {busy5, valid5, ovf5}, seg_left5, seg_right5);
        end
        q5.delete();
        free5 = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        load5_at(5);
        drain5();
    endtask

    task automatic test_width7();
        load7_at(120);
        drain7();
        load7_at(99);
        drain7();
        load7_at(100);
        drain7();
        load7_at(127);
        drain7();
        load7_at(7);
        drain7();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_digits();
        test_load_while_busy();
        test_back_to_back();
        test_abort();
        test_width7();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
